wb_interconnect_tag_nx1_arb: RTL and testbench
==============================================

Name: wb_interconnect_tag_nx1_arb

Overview:
- Wishbone tag interconnect that merges N initiator ports onto one downstream initiator port toward a single target.
- Round-robin arbitration with a registered grant; a grant is held for a whole bus cycle (t_cyc high).
- Complements the 1xN decode interconnect: it is the many-initiator end feeding one shared target, such as a memory or the 1xN fabric's passthrough.
- Data and address paths are combinational; arbitration is sequential.

Parameters:
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; select width is DAT_WIDTH/8.
- TGA_WIDTH, 4, address tag width.
- TGD_WIDTH, 4, data tag width.
- TGC_WIDTH, 4, cycle tag width.
- N_INITIATORS, 2, number of upstream ports; range 1..16.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- t_adr  input  N_INITIATORS*ADR_WIDTH  per-port address.
- t_dat_w  input  N_INITIATORS*DAT_WIDTH  per-port write data.
- t_sel  input  N_INITIATORS*(DAT_WIDTH/8)  per-port byte selects.
- t_we, t_cyc, t_stb  input  N_INITIATORS  per-port control.
- t_tga, t_tgc, t_tgd_w  input  N_INITIATORS*(TGA/TGC/TGD_WIDTH)  per-port tags.
- t_dat_r  output  N_INITIATORS*DAT_WIDTH  read data, broadcast to all ports.
- t_tgd_r  output  N_INITIATORS*TGD_WIDTH  read tag, broadcast to all ports.
- t_ack, t_err  output  N_INITIATORS  per-port responses.
- i_adr, i_dat_w, i_sel, i_we, i_tga, i_tgc, i_tgd_w  output  scalar widths  muxed request to the target.
- i_cyc, i_stb  output  1  muxed cycle and strobe.
- i_dat_r, i_tgd_r, i_ack, i_err  input  scalar widths  target response.

Behaviour:
State:
- `state` is IDLE or BUSY.
- `gnt` is a $clog2(N_INITIATORS)-bit index, minimum 1 bit.
- `last` is the index of the previous winner.

Reset (asynchronous, takes effect immediately):
- state=IDLE, gnt=0, last=N_INITIATORS-1, so port 0 has first priority.
- i_cyc=0, i_stb=0, all t_ack=0, all t_err=0.

IDLE:
- If any t_cyc bit is set, pick the winner: the first set bit scanning last+1, last+2, … modulo N_INITIATORS.
- On the next edge: gnt<=winner, last<=winner, state<=BUSY.
- Arbitration latency is 1 cycle. i_cyc and i_stb stay 0 throughout IDLE.

BUSY:
- i_cyc = t_cyc[gnt]; i_stb = t_stb[gnt].
- All i_* request fields come from port gnt.
- t_ack[gnt]=i_ack and t_err[gnt]=i_err. All other t_ack and t_err bits are 0.
- t_dat_r and t_tgd_r are broadcast from i_dat_r and i_tgd_r regardless of grant.

BUSY exit:
- If t_cyc[gnt]==0 at an edge, state<=IDLE.
- The next grant needs a fresh IDLE cycle, so there is 1 dead cycle between ownership changes.
- A port that drops cyc while the response is asserted still sees its ack in that same cycle (combinational path).

Locking:
- The grant persists across multiple stb phases while t_cyc[gnt] stays high.
- No preemption and no timeout.

Other ports:
- Non-granted ports may assert cyc and stb freely. They see no ack and no err until granted.

Output values in IDLE:
- i_adr and the other request fields carry port gnt's values; they are don't-care while i_cyc=0.

N_INITIATORS=1:
- Degenerates to pass-through with the 1-cycle IDLE→BUSY latency.

Reset mid-cycle:
- i_cyc drops asynchronously; the transfer in flight is abandoned and no ack reaches any port.

Widths:
- Round-robin index arithmetic is modulo N_INITIATORS. Non-power-of-two N must never select an index ≥N.

Test Plan:
1. Single request: port 0 asserts cyc/stb/we with adr=0x1000, dat_w=0xA5A5A5A5 at cycle 0 → i_cyc=1 from cycle 1 with i_adr=0x1000; target ack in cycle 2 → t_ack=0b01 in cycle 2.
2. Contention, N=4: ports 1 and 3 both request from reset → port 1 is served first. After port 1 drops cyc, 1 dead cycle, then port 3 is granted. Next simultaneous request from 1 and 3 → port 3 is skipped and port 1 wins (last=3).
3. Locked burst: port 2 holds cyc through 4 stb/ack pairs while port 0 requests → i_adr follows port 2 for all 4 beats; port 0 is granted only after port 2 drops cyc.
4. Error routing: target returns i_err=1 to granted port 1 → t_err=0b0010 and t_ack=0.
5. Reset mid-cycle: assert reset while BUSY with i_cyc=1 → i_cyc=0 in the same cycle; after release, port 0 has first priority.
6. N=3 wrap: last=2, ports 0 and 1 request → port 0 wins; grant index never reaches 3.

Source files
------------

// File: rtl/wb_interconnect_tag_nx1_arb.sv
// wb_interconnect_tag_nx1_arb
//
// Purpose:
//   This block merges N_INITIATORS Wishbone initiator ports, tags included,
//   onto one downstream initiator port that feeds a single shared target.
//   Arbitration is round-robin with a registered grant:
//     - While the arbiter is IDLE, it picks a winner from the ports that have
//       cyc asserted.
//     - On the next edge the winner owns the bus (BUSY).
//     - The winner keeps the bus for as long as its cyc stays high.
//   The request and response data paths are purely combinational.
//
// Ports:
//   clock, reset     sole clock; asynchronous active-high reset
//   t_*  (inputs)    per-port request fields, packed with port 0 in the LSBs
//   t_dat_r/t_tgd_r  read data and tag, broadcast to every port
//   t_ack/t_err      per-port responses; only the granted port sees them
//   i_*  (outputs)   muxed request toward the target
//   i_dat_r/i_tgd_r/i_ack/i_err  response from the target
module wb_interconnect_tag_nx1_arb #(
  parameter int ADR_WIDTH    = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int TGA_WIDTH    = 4,
  parameter int TGD_WIDTH    = 4,
  parameter int TGC_WIDTH    = 4,
  parameter int N_INITIATORS = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  // upstream (target-side) ports
  input  logic [N_INITIATORS*ADR_WIDTH-1:0]     t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0]     t_dat_w,
  input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0] t_sel,
  input  logic [N_INITIATORS-1:0]               t_we,
  input  logic [N_INITIATORS-1:0]               t_cyc,
  input  logic [N_INITIATORS-1:0]               t_stb,
  input  logic [N_INITIATORS*TGA_WIDTH-1:0]     t_tga,
  input  logic [N_INITIATORS*TGC_WIDTH-1:0]     t_tgc,
  input  logic [N_INITIATORS*TGD_WIDTH-1:0]     t_tgd_w,
  output logic [N_INITIATORS*DAT_WIDTH-1:0]     t_dat_r,
  output logic [N_INITIATORS*TGD_WIDTH-1:0]     t_tgd_r,
  output logic [N_INITIATORS-1:0]               t_ack,
  output logic [N_INITIATORS-1:0]               t_err,
  // downstream (initiator-side) port
  output logic [ADR_WIDTH-1:0]                  i_adr,
  output logic [DAT_WIDTH-1:0]                  i_dat_w,
  output logic [DAT_WIDTH/8-1:0]                i_sel,
  output logic                                  i_we,
  output logic [TGA_WIDTH-1:0]                  i_tga,
  output logic [TGC_WIDTH-1:0]                  i_tgc,
  output logic [TGD_WIDTH-1:0]                  i_tgd_w,
  output logic                                  i_cyc,
  output logic                                  i_stb,
  input  logic [DAT_WIDTH-1:0]                  i_dat_r,
  input  logic [TGD_WIDTH-1:0]                  i_tgd_r,
  input  logic                                  i_ack,
  input  logic                                  i_err
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  localparam int GNT_WIDTH = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;
  // One extra bit, so that last + k (which can reach 2N-1) never overflows
  // before the modulo step.
  localparam int SUM_WIDTH = GNT_WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           r_state;
  logic [GNT_WIDTH-1:0] r_gnt;
  logic [GNT_WIDTH-1:0] r_last;

  logic [GNT_WIDTH-1:0] w_winner;
  logic                 w_found;
  logic [SUM_WIDTH-1:0] w_sum;
  logic                 w_busy;

  // Per-port fields, unpacked so that the grant index can select them directly.
  logic [ADR_WIDTH-1:0] w_adr_arr   [N_INITIATORS];
  logic [DAT_WIDTH-1:0] w_dat_arr   [N_INITIATORS];
  logic [SEL_WIDTH-1:0] w_sel_arr   [N_INITIATORS];
  logic [TGA_WIDTH-1:0] w_tga_arr   [N_INITIATORS];
  logic [TGC_WIDTH-1:0] w_tgc_arr   [N_INITIATORS];
  logic [TGD_WIDTH-1:0] w_tgd_w_arr [N_INITIATORS];

  genvar gi;
  generate
    for (gi = 0; gi < N_INITIATORS; gi++) begin : g_port
      assign w_adr_arr[gi]   = t_adr[gi*ADR_WIDTH +: ADR_WIDTH];
      assign w_dat_arr[gi]   = t_dat_w[gi*DAT_WIDTH +: DAT_WIDTH];
      assign w_sel_arr[gi]   = t_sel[gi*SEL_WIDTH +: SEL_WIDTH];
      assign w_tga_arr[gi]   = t_tga[gi*TGA_WIDTH +: TGA_WIDTH];
      assign w_tgc_arr[gi]   = t_tgc[gi*TGC_WIDTH +: TGC_WIDTH];
      assign w_tgd_w_arr[gi] = t_tgd_w[gi*TGD_WIDTH +: TGD_WIDTH];

      // Read data and tag go to every port; ack and err go only to the owner.
      assign t_dat_r[gi*DAT_WIDTH +: DAT_WIDTH] = i_dat_r;
      assign t_tgd_r[gi*TGD_WIDTH +: TGD_WIDTH] = i_tgd_r;
      assign t_ack[gi] = w_busy && (r_gnt == GNT_WIDTH'(gi)) && i_ack;
      assign t_err[gi] = w_busy && (r_gnt == GNT_WIDTH'(gi)) && i_err;
    end
  endgenerate

  // Round-robin scan: test last+1, last+2, ..., last+N (mod N) in order.
  // The first port found with cyc set wins. The modulo is a single
  // conditional subtract, because the sum never reaches 2N. This means an
  // index >= N is never produced, even when N is not a power of two.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int k = 1; k <= N_INITIATORS; k++) begin
      w_sum = {1'b0, r_last} + SUM_WIDTH'(k);
      if (w_sum >= SUM_WIDTH'(N_INITIATORS)) begin
        w_sum = w_sum - SUM_WIDTH'(N_INITIATORS);
      end
      if (!w_found && t_cyc[w_sum[GNT_WIDTH-1:0]]) begin
        w_winner = w_sum[GNT_WIDTH-1:0];
        w_found  = 1'b1;
      end
    end
  end

  assign w_busy = (r_state == BUSY);

  // The request fields always follow port gnt. cyc and stb are gated by
  // BUSY, and BUSY clears asynchronously on reset. So a reset in the middle
  // of a cycle drops i_cyc at once, and no late ack can reach any port.
  assign i_adr   = w_adr_arr[r_gnt];
  assign i_dat_w = w_dat_arr[r_gnt];
  assign i_sel   = w_sel_arr[r_gnt];
  assign i_we    = t_we[r_gnt];
  assign i_tga   = w_tga_arr[r_gnt];
  assign i_tgc   = w_tgc_arr[r_gnt];
  assign i_tgd_w = w_tgd_w_arr[r_gnt];
  assign i_cyc   = w_busy && t_cyc[r_gnt];
  assign i_stb   = w_busy && t_stb[r_gnt];

  // Arbitration state. After reset, last points at the highest port, so
  // port 0 is the first one scanned. The grant is held until the owner
  // drops cyc. The drop always passes through IDLE, which costs one dead
  // cycle between owners.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= GNT_WIDTH'(N_INITIATORS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|t_cyc) begin
            r_gnt   <= w_winner;
            r_last  <= w_winner;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!t_cyc[r_gnt]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect_tag_nx1_arb.sv
// Testbench for wb_interconnect_tag_nx1_arb.
// It instantiates two DUTs:
//   - a 4-port DUT, used for the main arbitration scenarios;
//   - a 3-port DUT, used for the non-power-of-two wrap case.
// The expected values are constants worked out by hand.
module tb_wb_interconnect_tag_nx1_arb;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // shared target response
  logic [31:0] i_dat_r;
  logic [3:0]  i_tgd_r;
  logic        i_ack;
  logic        i_err;

  // 4-port DUT
  logic [127:0] t_adr4, t_dat_w4, t_dat_r4;
  logic [15:0]  t_sel4, t_tga4, t_tgc4, t_tgd_w4, t_tgd_r4;
  logic [3:0]   t_we4, t_cyc4, t_stb4, t_ack4, t_err4;
  logic [31:0]  i_adr4, i_dat_w4;
  logic [3:0]   i_sel4, i_tga4, i_tgc4, i_tgd_w4;
  logic         i_we4, i_cyc4, i_stb4;

  // 3-port DUT
  logic [95:0]  t_adr3, t_dat_w3, t_dat_r3;
  logic [11:0]  t_sel3, t_tga3, t_tgc3, t_tgd_w3, t_tgd_r3;
  logic [2:0]   t_we3, t_cyc3, t_stb3, t_ack3, t_err3;
  logic [31:0]  i_adr3, i_dat_w3;
  logic [3:0]   i_sel3, i_tga3, i_tgc3, i_tgd_w3;
  logic         i_we3, i_cyc3, i_stb3;

  int checks_count = 0;
  int errors_count = 0;

  wb_interconnect_tag_nx1_arb #(.N_INITIATORS(4)) dut4 (
    .clock(clock), .reset(reset),
    .t_adr(t_adr4), .t_dat_w(t_dat_w4), .t_sel(t_sel4), .t_we(t_we4),
    .t_cyc(t_cyc4), .t_stb(t_stb4), .t_tga(t_tga4), .t_tgc(t_tgc4),
    .t_tgd_w(t_tgd_w4), .t_dat_r(t_dat_r4), .t_tgd_r(t_tgd_r4),
    .t_ack(t_ack4), .t_err(t_err4),
    .i_adr(i_adr4), .i_dat_w(i_dat_w4), .i_sel(i_sel4), .i_we(i_we4),
    .i_tga(i_tga4), .i_tgc(i_tgc4), .i_tgd_w(i_tgd_w4),
    .i_cyc(i_cyc4), .i_stb(i_stb4),
    .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r), .i_ack(i_ack), .i_err(i_err)
  );

  wb_interconnect_tag_nx1_arb #(.N_INITIATORS(3)) dut3 (
    .clock(clock), .reset(reset),
    .t_adr(t_adr3), .t_dat_w(t_dat_w3), .t_sel(t_sel3), .t_we(t_we3),
    .t_cyc(t_cyc3), .t_stb(t_stb3), .t_tga(t_tga3), .t_tgc(t_tgc3),
    .t_tgd_w(t_tgd_w3), .t_dat_r(t_dat_r3), .t_tgd_r(t_tgd_r3),
    .t_ack(t_ack3), .t_err(t_err3),
    .i_adr(i_adr3), .i_dat_w(i_dat_w3), .i_sel(i_sel3), .i_we(i_we3),
    .i_tga(i_tga3), .i_tgc(i_tgc3), .i_tgd_w(i_tgd_w3),
    .i_cyc(i_cyc3), .i_stb(i_stb3),
    .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r), .i_ack(i_ack), .i_err(i_err)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_count++;
    if (got !== exp) begin
      errors_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after settling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req4(input int p, input logic cyc, input logic [31:0] adr);
    t_cyc4[p] = cyc;
    t_stb4[p] = cyc;
    t_adr4[p*32 +: 32] = adr;
  endtask

  task automatic req3(input int p, input logic cyc, input logic [31:0] adr);
    t_cyc3[p] = cyc;
    t_stb3[p] = cyc;
    t_adr3[p*32 +: 32] = adr;
  endtask

  initial begin
    t_adr4 = '0; t_dat_w4 = '0; t_sel4 = '0; t_we4 = '0; t_cyc4 = '0; t_stb4 = '0;
    t_tga4 = '0; t_tgc4 = '0; t_tgd_w4 = '0;
    t_adr3 = '0; t_dat_w3 = '0; t_sel3 = '0; t_we3 = '0; t_cyc3 = '0; t_stb3 = '0;
    t_tga3 = '0; t_tgc3 = '0; t_tgd_w3 = '0;
    i_dat_r = '0; i_tgd_r = '0; i_ack = 1'b1; i_err = 1'b1;
    reset = 1'b1;
    step();
    #1;
    check_value("reset_i_cyc", i_cyc4, 0);
    check_value("reset_i_stb", i_stb4, 0);
    check_value("reset_t_ack", t_ack4, 0);
    check_value("reset_t_err", t_err4, 0);
    step();
    reset = 1'b0;
    i_ack = 1'b0; i_err = 1'b0;

    // 1. Single request from port 0
    req4(0, 1'b1, 32'h1000);
    t_we4[0] = 1'b1;
    t_dat_w4[31:0] = 32'hA5A5A5A5;
    #1 check_value("t1_idle_cyc", i_cyc4, 0);
    step();
    #1 check_value("t1_cyc", i_cyc4, 1);
    check_value("t1_adr", i_adr4, 32'h1000);
    check_value("t1_dat_w", i_dat_w4, 32'hA5A5A5A5);
    check_value("t1_we", i_we4, 1);
    step();
    i_ack = 1'b1;
    req4(0, 1'b0, 32'h1000);   // drop cyc while the ack is asserted
    t_we4[0] = 1'b0;
    #1 check_value("t1_ack", t_ack4, 4'b0001);
    step();
    i_ack = 1'b0;

    // 2. Contention between ports 1 and 3, starting from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    req4(1, 1'b1, 32'h1100);
    req4(3, 1'b1, 32'h3300);
    step();
    #1 check_value("t2_first_adr", i_adr4, 32'h1100);
    check_value("t2_first_cyc", i_cyc4, 1);
    i_ack = 1'b1;
    #1 check_value("t2_first_ack", t_ack4, 4'b0010);
    step();
    i_ack = 1'b0;
    req4(1, 1'b0, 32'h1100);
    #1 check_value("t2_drop_cyc", i_cyc4, 0);
    step();
    #1 check_value("t2_dead_cyc", i_cyc4, 0);
    step();
    #1 check_value("t2_second_adr", i_adr4, 32'h3300);
    check_value("t2_second_cyc", i_cyc4, 1);
    i_ack = 1'b1;
    #1 check_value("t2_second_ack", t_ack4, 4'b1000);
    step();
    i_ack = 1'b0;
    req4(3, 1'b0, 32'h3300);
    step();
    req4(1, 1'b1, 32'h1104);
    req4(3, 1'b1, 32'h3304);
    step();
    #1 check_value("t2_rr_adr", i_adr4, 32'h1104);
    req4(1, 1'b0, 32'h1104);
    req4(3, 1'b0, 32'h3304);
    step();

    // 3. Locked burst on port 2 while port 0 waits (last=1)
    req4(2, 1'b1, 32'h2000);
    req4(0, 1'b1, 32'h0500);
    step();
    for (int b = 0; b < 4; b++) begin
      t_adr4[2*32 +: 32] = 32'h2000 + 32'(4*b);
      i_ack = 1'b1;
      #1 check_value($sformatf("t3_beat%0d_adr", b), i_adr4, 32'h2000 + 64'(4*b));
      check_value($sformatf("t3_beat%0d_ack", b), t_ack4, 4'b0100);
      step();
    end
    i_ack = 1'b0;
    req4(2, 1'b0, 32'h200C);
    #1 check_value("t3_drop_cyc", i_cyc4, 0);
    step();
    #1 check_value("t3_dead_cyc", i_cyc4, 0);
    step();
    #1 check_value("t3_port0_adr", i_adr4, 32'h0500);
    check_value("t3_port0_cyc", i_cyc4, 1);

    // 4. An error response goes to granted port 1 only
    req4(0, 1'b0, 32'h0500);
    step();
    req4(1, 1'b1, 32'h1200);
    step();
    i_err = 1'b1;
    i_dat_r = 32'hDEADBEEF;
    i_tgd_r = 4'hA;
    #1 check_value("t4_err", t_err4, 4'b0010);
    check_value("t4_ack", t_ack4, 4'b0000);
    check_value("t4_dat_r_bcast", t_dat_r4[95:64], 32'hDEADBEEF);
    check_value("t4_tgd_r_bcast", t_tgd_r4[15:12], 4'hA);
    i_err = 1'b0;

    // 5. Reset while BUSY
    i_ack = 1'b1;
    #1 check_value("t5_busy_cyc", i_cyc4, 1);
    reset = 1'b1;
    #1 check_value("t5_reset_cyc", i_cyc4, 0);
    check_value("t5_reset_ack", t_ack4, 4'b0000);
    req4(1, 1'b0, 32'h1200);
    req4(0, 1'b1, 32'h0600);
    req4(2, 1'b1, 32'h2600);
    i_ack = 1'b0;
    step();
    reset = 1'b0;
    step();
    #1 check_value("t5_port0_first", i_adr4, 32'h0600);
    req4(0, 1'b0, 32'h0600);
    req4(2, 1'b0, 32'h2600);

    // 6. N=3 wrap: ports 0 and 1 request while last=2, so port 0 wins
    req3(2, 1'b1, 32'h2A00);
    step();
    #1 check_value("t6_port2_adr", i_adr3, 32'h2A00);
    check_value("t6_port2_cyc", i_cyc3, 1);
    req3(2, 1'b0, 32'h2A00);
    step();
    req3(0, 1'b1, 32'h0A00);
    req3(1, 1'b1, 32'h1A00);
    step();
    #1 check_value("t6_wrap_adr", i_adr3, 32'h0A00);
    i_ack = 1'b1;
    #1 check_value("t6_wrap_ack", t_ack3, 3'b001);
    i_ack = 1'b0;
    req3(0, 1'b0, 32'h0A00);
    step();
    step();
    #1 check_value("t6_next_adr", i_adr3, 32'h1A00);
    check_value("t6_next_cyc", i_cyc3, 1);
    req3(1, 1'b0, 32'h1A00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks_count, errors_count);
    $finish;
  end

endmodule
